// File: rtl/seg_scan_ctrl_if.sv
// Request/data bundle from the two display requesters and the scanned pin outputs.
interface seg_scan_ctrl_if;
  logic [1:0]  req;
  logic [23:0] data0;
  logic [23:0] data1;
  logic [5:0]  dp0;
  logic [5:0]  dp1;
  logic [1:0]  gnt;
  logic        frame_done;
  logic [7:0]  number;
  logic [5:0]  digit_block;

  modport master (
    output req, data0, data1, dp0, dp1,
    input  gnt, frame_done, number, digit_block
  );

  modport slave (
    input  req, data0, data1, dp0, dp1,
    output gnt, frame_done, number, digit_block
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Frame-boundary arbiter and 6-digit active-low 7-segment scanner for two requesters.
// Optional feature: define SEG_BLANK_LEADING_ZERO_EN to blank leading zero digits.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV    = 4096,
  parameter int unsigned HOLD_FRAMES = 16
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave io_disp
);

  localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(HOLD_FRAMES);

  typedef enum logic [1:0] {
    OwnNone = 2'b00,
    OwnTime = 2'b01,
    OwnMsg  = 2'b10
  } owner_e;

  owner_e           r_owner, w_owner_d;
  owner_e           w_fresh, w_other;
  logic [SlotW-1:0] r_slot, w_slot_d;
  logic [2:0]       r_digit, w_digit_d;
  logic [HoldW-1:0] r_hold, w_hold_d;
  logic [23:0]      r_snap, w_snap_d;
  logic [5:0]       r_snap_dp, w_snap_dp_d;
  logic [5:0]       r_blank, w_blank_d;
  logic             r_frame_done, w_frame_done_d;
  logic [7:0]       r_number, w_number_d;
  logic [5:0]       r_digit_block, w_digit_block_d;
  logic             w_boundary;
  logic             w_own_req, w_other_req, w_hold_done;
  logic [3:0]       w_nib;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hF:    seg = 8'hBF;
      default: seg = 8'hFF;
    endcase
    return seg;
  endfunction

`ifdef SEG_BLANK_LEADING_ZERO_EN
  // Walk from digit 5 downward; digit 0 always stays lit.
  function automatic logic [5:0] lead_zero_mask(input logic [23:0] digits);
    logic [5:0] mask;
    logic       leading;
    mask    = '0;
    leading = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      if (digits[4*k +: 4] != 4'd0) leading = 1'b0;
      mask[k] = leading;
    end
    return mask;
  endfunction
`endif

  assign w_boundary = (r_slot == SlotLast) && (r_digit == 3'd5);

  always_comb begin
    w_slot_d  = r_slot + 1'b1;
    w_digit_d = r_digit;
    if (r_slot == SlotLast) begin
      w_slot_d  = '0;
      w_digit_d = (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
    end
  end

  // Owner next-state: only evaluated on the last cycle of a frame.
  always_comb begin
    w_fresh     = io_disp.req[1] ? OwnMsg : (io_disp.req[0] ? OwnTime : OwnNone);
    w_other     = (r_owner == OwnTime) ? OwnMsg : OwnTime;
    w_own_req   = |(io_disp.req & r_owner);
    w_other_req = |(io_disp.req & w_other);
    w_hold_done = (32'(r_hold) + 32'd1) >= HOLD_FRAMES;
    w_owner_d   = r_owner;
    w_hold_d    = r_hold;
    if (w_boundary) begin
      if ((r_owner == OwnNone) || !w_own_req) begin
        w_owner_d = w_fresh;
      end else if (w_other_req && w_hold_done) begin
        w_owner_d = w_other;
      end
      if (w_owner_d != r_owner) begin
        w_hold_d = '0;
      end else if (r_hold != HoldMax) begin
        w_hold_d = r_hold + 1'b1;
      end
    end
  end

  always_comb begin
    w_snap_d    = r_snap;
    w_snap_dp_d = r_snap_dp;
    w_blank_d   = r_blank;
    if (w_boundary) begin
      unique case (w_owner_d)
        OwnTime: begin
          w_snap_d    = io_disp.data0;
          w_snap_dp_d = io_disp.dp0;
        end
        OwnMsg: begin
          w_snap_d    = io_disp.data1;
          w_snap_dp_d = io_disp.dp1;
        end
        default: begin
          w_snap_d    = '1;
          w_snap_dp_d = '0;
        end
      endcase
`ifdef SEG_BLANK_LEADING_ZERO_EN
      w_blank_d = lead_zero_mask(w_snap_d);
`else
      w_blank_d = '0;
`endif
    end
  end

  // Outputs are computed from next state so the registered pins line up with the slot.
  always_comb begin
    w_nib           = w_snap_d[{w_digit_d, 2'b00} +: 4];
    w_frame_done_d  = (w_slot_d == SlotLast) && (w_digit_d == 3'd5);
    w_number_d      = 8'hFF;
    w_digit_block_d = 6'b111111;
    if (w_owner_d != OwnNone) begin
      w_number_d = w_blank_d[w_digit_d] ? 8'hFF : seg_decode(w_nib);
      if (w_snap_dp_d[w_digit_d]) w_number_d[7] = 1'b0;
      if (w_slot_d != '0) w_digit_block_d = ~(6'd1 << w_digit_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner       <= OwnNone;
      r_slot        <= '0;
      r_digit       <= '0;
      r_hold        <= '0;
      r_snap        <= '1;
      r_snap_dp     <= '0;
      r_blank       <= '0;
      r_frame_done  <= 1'b0;
      r_number      <= 8'hFF;
      r_digit_block <= 6'b111111;
    end else begin
      r_owner       <= w_owner_d;
      r_slot        <= w_slot_d;
      r_digit       <= w_digit_d;
      r_hold        <= w_hold_d;
      r_snap        <= w_snap_d;
      r_snap_dp     <= w_snap_dp_d;
      r_blank       <= w_blank_d;
      r_frame_done  <= w_frame_done_d;
      r_number      <= w_number_d;
      r_digit_block <= w_digit_block_d;
    end
  end

  assign io_disp.gnt         = r_owner;
  assign io_disp.frame_done  = r_frame_done;
  assign io_disp.number      = r_number;
  assign io_disp.digit_block = r_digit_block;

endmodule
